// File: rtl/usbhid_gamepad_events.sv
// usbhid_gamepad_events: pulls a button bitmap out of each HID report, turns
// bit changes into a queued press/release/repeat event stream and forces a
// release of every button when the device stops sending reports.
module usbhid_gamepad_events #(
  parameter int C_report_bytes    = 20,
  parameter int C_btn_offset      = 2,
  parameter int C_btn_bits        = 16,
  parameter int C_fifo_depth      = 8,
  parameter int C_clk_hz          = 48000000,
  parameter int C_repeat_delay_ms = 500,
  parameter int C_repeat_rate_ms  = 100,
  parameter int C_timeout_ms      = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [C_report_bytes*8-1:0] hid_report,
  input  logic                        hid_valid,
  output logic [C_btn_bits-1:0]       btn_state,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [1:0]                  evt_type,
  output logic [4:0]                  evt_index,
  output logic                        stale,
  output logic                        overflow
);

  localparam int P     = C_clk_hz / 1000;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int MAXMS = (C_repeat_delay_ms > C_repeat_rate_ms) ?
                         ((C_repeat_delay_ms > C_timeout_ms) ? C_repeat_delay_ms : C_timeout_ms) :
                         ((C_repeat_rate_ms > C_timeout_ms) ? C_repeat_rate_ms : C_timeout_ms);
  localparam int TW    = $clog2(MAXMS + 1);
  localparam int SW    = (C_btn_bits > 1) ? $clog2(C_btn_bits) : 1;
  localparam int AW    = (C_fifo_depth > 1) ? $clog2(C_fifo_depth) : 1;
  localparam int CW    = AW + 1;

  localparam logic [SW-1:0] LAST  = SW'(C_btn_bits - 1);
  localparam logic [PW-1:0] PLAST = PW'(P - 1);
  localparam logic [TW-1:0] DELAY = TW'(C_repeat_delay_ms);
  localparam logic [TW-1:0] RATE  = TW'(C_repeat_rate_ms);
  localparam logic [TW-1:0] TOUT  = TW'(C_timeout_ms);
  localparam logic [CW-1:0] FULL  = CW'(C_fifo_depth);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         scan_idx;
  logic [C_btn_bits-1:0] diff, pend_val, field, arr_val, cap_val;
  logic                  pend_vld, arr_vld, cap, pend_set, pend_clr;
  logic [PW-1:0]         presc;
  logic                  tick, inject;
  logic [TW-1:0]         ms_cnt, rpt_cnt;
  logic                  rpt_armed, rpt_req;
  logic [SW-1:0]         rpt_tgt, rpt_idx;
  logic                  scan_push, scan_press, disarm, expire, rpt_fire, rpt_push;
  logic                  push, pop, full, accept;
  logic [1:0]            push_type;
  logic [4:0]            push_idx;
  logic [6:0]            mem [C_fifo_depth];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  // A timeout injects an all-zero report through the same path as a real one.
  assign field   = hid_report[8*C_btn_offset +: C_btn_bits];
  assign tick    = (presc == PLAST);
  assign inject  = tick && (ms_cnt == TOUT - TW'(1)) && !hid_valid;
  assign arr_vld = hid_valid || inject;
  assign arr_val = hid_valid ? field : '0;

  // Next state and report capture; reports arriving mid-scan park in pending.
  always_comb begin
    state_d  = state_q;
    cap      = 1'b0;
    cap_val  = arr_val;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      IDLE: if (arr_vld) begin
        cap = 1'b1;
        if ((btn_state ^ arr_val) != '0) state_d = SCAN;
      end
      SCAN: if (scan_idx == LAST) begin
        pend_clr = 1'b1;
        state_d  = IDLE;
        if (arr_vld || pend_vld) begin
          cap     = 1'b1;
          cap_val = arr_vld ? arr_val : pend_val;
          if ((btn_state ^ cap_val) != '0) state_d = SCAN;
        end
      end else if (arr_vld) begin
        pend_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, bitmap/diff capture and scan position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      scan_idx  <= '0;
      diff      <= '0;
      btn_state <= '0;
      pend_vld  <= 1'b0;
      pend_val  <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        btn_state <= cap_val;
        diff      <= btn_state ^ cap_val;
        scan_idx  <= '0;
      end else if (state_q == SCAN) begin
        scan_idx <= scan_idx + SW'(1);
      end
      if (pend_set) begin
        pend_vld <= 1'b1;
        pend_val <= arr_val;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // 1 ms prescaler, report-silence counter (saturating) and stale flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      ms_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (hid_valid) ms_cnt <= '0;
      else if (tick && ms_cnt != TOUT) ms_cnt <= ms_cnt + TW'(1);
      if (hid_valid) stale <= 1'b0;
      else if (inject) stale <= 1'b1;
    end
  end

  assign scan_push  = (state_q == SCAN) && diff[scan_idx];
  assign scan_press = scan_push && btn_state[scan_idx];
  assign disarm     = inject || (scan_push && !btn_state[scan_idx] && scan_idx == rpt_tgt);
  assign expire     = tick && rpt_armed && (rpt_cnt <= TW'(1));
  assign rpt_fire   = expire && btn_state[rpt_tgt] && !scan_press && !disarm;
  assign rpt_push   = rpt_req && !scan_push;

  // Single-target repeat timer; a fired repeat waits in rpt_req until a free slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_armed <= 1'b0;
      rpt_tgt   <= '0;
      rpt_cnt   <= '0;
      rpt_req   <= 1'b0;
      rpt_idx   <= '0;
    end else begin
      if (scan_press) begin
        rpt_armed <= 1'b1;
        rpt_tgt   <= scan_idx;
        rpt_cnt   <= DELAY;
      end else if (disarm) begin
        rpt_armed <= 1'b0;
      end else if (tick && rpt_armed) begin
        if (expire) begin
          if (btn_state[rpt_tgt]) rpt_cnt <= RATE;
          else rpt_armed <= 1'b0;
        end else begin
          rpt_cnt <= rpt_cnt - TW'(1);
        end
      end
      if (rpt_fire) begin
        rpt_req <= 1'b1;
        rpt_idx <= rpt_tgt;
      end else if (rpt_push) begin
        rpt_req <= 1'b0;
      end
    end
  end

  assign push      = scan_push || rpt_push;
  assign push_type = scan_push ? (btn_state[scan_idx] ? 2'b01 : 2'b10) : 2'b11;
  assign push_idx  = scan_push ? 5'(scan_idx) : 5'(rpt_idx);
  assign evt_valid = (count != '0);
  assign full      = (count == FULL);
  assign pop       = evt_valid && evt_ready;
  assign accept    = push && (!full || pop);
  assign evt_type  = evt_valid ? mem[rd_ptr][6:5] : 2'b00;
  assign evt_index = evt_valid ? mem[rd_ptr][4:0] : 5'd0;

  // Event storage; no reset needed, reads are gated by evt_valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {push_type, push_idx};
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usbhid_gamepad_events.sv
// Directed bench for usbhid_gamepad_events at 10 cycles per ms.
module tb_usbhid_gamepad_events;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [159:0] hid_report = '0;
  logic         hid_valid = 1'b0;
  logic [15:0]  btn_state;
  logic         evt_valid;
  logic         evt_ready = 1'b1;
  logic [1:0]   evt_type;
  logic [4:0]   evt_index;
  logic         stale;
  logic         overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int press2_cyc = 0;

  typedef struct {
    logic [1:0] t;
    logic [4:0] i;
    int         c;
  } ev_t;
  ev_t evq[$];

  usbhid_gamepad_events #(
    .C_report_bytes(20), .C_btn_offset(2), .C_btn_bits(16), .C_fifo_depth(8),
    .C_clk_hz(10000), .C_repeat_delay_ms(5), .C_repeat_rate_ms(2), .C_timeout_ms(20)
  ) dut (
    .clk(clk), .reset(reset), .hid_report(hid_report), .hid_valid(hid_valid),
    .btn_state(btn_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_type(evt_type), .evt_index(evt_index), .stale(stale), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted event with its cycle stamp.
  always @(posedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      ev_t e;
      e.t = evt_type;
      e.i = evt_index;
      e.c = cyc;
      evq.push_back(e);
    end
  end

  task automatic send(input logic [15:0] v);
    @(negedge clk);
    hid_report = '0;
    hid_report[16 +: 16] = v;
    hid_valid = 1'b1;
    @(negedge clk);
    hid_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hid_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (btn_state !== 16'h0) begin bad++; $display("FAIL rst_btn got=%h exp=0000", btn_state); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_evt_valid got=%b exp=0", evt_valid); end
    total++; if ({evt_type, evt_index} !== 7'd0) begin bad++; $display("FAIL rst_evt_data got=%h exp=00", {evt_type, evt_index}); end
    total++; if ({stale, overflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {stale, overflow}); end
    reset = 1'b0;
  endtask

  task automatic test_press();
    evq.delete();
    evt_ready = 1'b1;
    send(16'h0005);
    total++; if (btn_state !== 16'h0005) begin bad++; $display("FAIL s1_btn got=%h exp=0005", btn_state); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL s1_t1_valid got=%b exp=0", evt_valid); end
    @(negedge clk);
    total++; if ({evt_valid, evt_type, evt_index} !== {1'b1, 2'b01, 5'd0}) begin
      bad++; $display("FAIL s1_t2_evt got=%b/%b/%0d exp=1/01/0", evt_valid, evt_type, evt_index); end
    @(negedge clk);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL s1_t3_valid got=%b exp=0", evt_valid); end
    @(negedge clk);
    total++; if ({evt_valid, evt_type, evt_index} !== {1'b1, 2'b01, 5'd2}) begin
      bad++; $display("FAIL s1_t4_evt got=%b/%b/%0d exp=1/01/2", evt_valid, evt_type, evt_index); end
    repeat (16) @(negedge clk);
    total++; if (evq.size() != 2) begin bad++; $display("FAIL s1_count got=%0d exp=2", evq.size()); end
    if (evq.size() >= 2) press2_cyc = evq[1].c;
  endtask

  task automatic test_repeat();
    int rel0, rep1, rep2, rel2, late_rep;
    evq.delete();
    send(16'h0004);
    for (int k = 0; k < 12; k++) begin
      repeat (8) @(negedge clk);
      send(16'h0004);
    end
    rel0 = 0; rep1 = -1; rep2 = -1;
    foreach (evq[k]) begin
      if (evq[k].t == 2'b10 && evq[k].i == 5'd0) rel0++;
      if (evq[k].t == 2'b11 && evq[k].i == 5'd2) begin
        if (rep1 < 0) rep1 = evq[k].c;
        else if (rep2 < 0) rep2 = evq[k].c;
      end
    end
    total++; if (rel0 != 1) begin bad++; $display("FAIL s2_rel0 got=%0d exp=1", rel0); end
    total++; if (rep1 < 0 || (rep1 - press2_cyc) < 40 || (rep1 - press2_cyc) > 52) begin
      bad++; $display("FAIL s2_first_rep got=%0d exp=40..52", rep1 - press2_cyc); end
    total++; if (rep2 < 0 || (rep2 - rep1) != 20) begin
      bad++; $display("FAIL s2_rep_rate got=%0d exp=20", rep2 - rep1); end
    evq.delete();
    send(16'h0000);
    repeat (60) @(negedge clk);
    rel2 = -1; late_rep = 0;
    foreach (evq[k]) begin
      if (evq[k].t == 2'b10 && evq[k].i == 5'd2) rel2 = evq[k].c;
      else if (evq[k].t == 2'b11 && rel2 >= 0) late_rep++;
    end
    total++; if (rel2 < 0) begin bad++; $display("FAIL s2_rel2 got=none exp=release2"); end
    total++; if (late_rep != 0) begin bad++; $display("FAIL s2_late_rep got=%0d exp=0", late_rep); end
  endtask

  task automatic test_overflow();
    do_reset();
    evq.delete();
    evt_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send(16'((32'd1 << (k + 1)) - 1));
      repeat (18) @(negedge clk);
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL s3_ovf got=%b exp=1", overflow); end
    total++; if (btn_state !== 16'h01FF) begin bad++; $display("FAIL s3_btn got=%h exp=01ff", btn_state); end
    total++; if ({evt_valid, evt_type, evt_index} !== {1'b1, 2'b01, 5'd0}) begin
      bad++; $display("FAIL s3_head got=%b/%b/%0d exp=1/01/0", evt_valid, evt_type, evt_index); end
    evt_ready = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (evq.size() != 8) begin bad++; $display("FAIL s3_drain_cnt got=%0d exp=8", evq.size()); end
    for (int k = 0; k < 8 && k < evq.size(); k++) begin
      total++; if (evq[k].t !== 2'b01 || evq[k].i !== 5'(k) || evq[k].c != evq[0].c + k) begin
        bad++; $display("FAIL s3_drain%0d got=%b/%0d@+%0d exp=01/%0d@+%0d", k, evq[k].t, evq[k].i, evq[k].c - evq[0].c, k, k); end
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL s3_empty got=%b exp=0", evt_valid); end
  endtask

  task automatic test_pending();
    do_reset();
    evq.delete();
    evt_ready = 1'b1;
    @(negedge clk);
    hid_report = '0; hid_report[16 +: 16] = 16'h0003; hid_valid = 1'b1;
    @(negedge clk);
    hid_valid = 1'b0;
    @(negedge clk);
    hid_report[16 +: 16] = 16'hFFFF; hid_valid = 1'b1;
    @(negedge clk);
    hid_report[16 +: 16] = 16'h0001;
    @(negedge clk);
    hid_valid = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (btn_state !== 16'h0001) begin bad++; $display("FAIL s4_btn got=%h exp=0001", btn_state); end
    total++; if (evq.size() != 3) begin bad++; $display("FAIL s4_count got=%0d exp=3", evq.size()); end
    if (evq.size() == 3) begin
      total++; if ({evq[0].t, evq[0].i, evq[1].t, evq[1].i, evq[2].t, evq[2].i} !==
                   {2'b01, 5'd0, 2'b01, 5'd1, 2'b10, 5'd1}) begin
        bad++; $display("FAIL s4_seq got=%b/%0d %b/%0d %b/%0d exp=01/0 01/1 10/1",
                        evq[0].t, evq[0].i, evq[1].t, evq[1].i, evq[2].t, evq[2].i); end
    end
  endtask

  task automatic test_timeout();
    int t0, ts, rels, bad_after, n_before;
    bit seen_rel;
    do_reset();
    evq.delete();
    evt_ready = 1'b1;
    send(16'h0003);
    t0 = cyc;
    for (int k = 0; k < 400 && !stale; k++) @(negedge clk);
    ts = cyc;
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL s5_stale got=%b exp=1", stale); end
    total++; if ((ts - t0) < 185 || (ts - t0) > 210) begin
      bad++; $display("FAIL s5_stale_time got=%0d exp=185..210", ts - t0); end
    repeat (30) @(negedge clk);
    total++; if (btn_state !== 16'h0000) begin bad++; $display("FAIL s5_btn got=%h exp=0000", btn_state); end
    rels = 0; bad_after = 0; seen_rel = 0;
    foreach (evq[k]) begin
      if (evq[k].t == 2'b10) begin
        seen_rel = 1;
        if (evq[k].i == 5'(rels)) rels++;
        else bad_after++;
      end else if (seen_rel) bad_after++;
    end
    total++; if (rels != 2 || bad_after != 0) begin
      bad++; $display("FAIL s5_releases got=%0d/%0d exp=2/0", rels, bad_after); end
    n_before = evq.size();
    send(16'h0000);
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL s5_unstale got=%b exp=0", stale); end
    repeat (20) @(negedge clk);
    total++; if (evq.size() != n_before) begin bad++; $display("FAIL s5_no_evt got=%0d exp=%0d", evq.size(), n_before); end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    evq.delete();
    evt_ready = 1'b0;
    send(16'hFFFF);
    repeat (12) @(negedge clk);
    total++; if ({evt_valid, overflow} !== 2'b11) begin
      bad++; $display("FAIL s6_pre got=%b exp=11", {evt_valid, overflow}); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({evt_valid, overflow, stale} !== 3'b000 || btn_state !== 16'h0) begin
      bad++; $display("FAIL s6_post got=%b/%h exp=000/0000", {evt_valid, overflow, stale}, btn_state); end
    reset = 1'b0;
    evt_ready = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (evq.size() != 0) begin bad++; $display("FAIL s6_residual got=%0d exp=0", evq.size()); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_repeat();
    test_overflow();
    test_pending();
    test_timeout();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
